// File: rtl/cpu_mem_bus_ctrl.sv
// CPU memory/IO bus controller: word RAM plus a 16-word MMIO window, fixed-latency handshake.
// Optional out-of-range error reporting is enabled with `define MEM_BUS_OOR_ERR_EN.
module cpu_mem_bus_ctrl #(
    parameter int          DEPTH       = 1024,
    parameter int          WAIT_CYCLES = 1,
    parameter logic [15:0] MMIO_BASE   = 16'hFFF0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic [15:0] base,
    input  logic        flag,
    input  logic [15:0] wdata,
    output logic [15:0] rdata,
    output logic        ready,
    input  logic [15:0] in,
    output logic [15:0] out_port,
    output logic        out_strobe,
    output logic        err
);
    localparam int          AW      = $clog2(DEPTH);
    localparam logic [16:0] DEPTH_L = 17'(DEPTH);
    localparam logic [3:0]  WAIT_L  = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t      state_reg, state_next;
    logic [3:0]  cnt_reg, cnt_next;
    logic [15:0] addr_reg;
    logic        wr_reg;
    logic [15:0] wdata_reg;
    logic        complete;

    logic [15:0] mem [DEPTH];
    logic [15:0] ram_q;
    logic        src_ram_reg;
    logic [15:0] mmio_q_reg;
    logic [15:0] mmio_rd;
    logic [15:0] status_word;
    logic [15:0] out_port_reg;
    logic        ready_reg;
    logic        out_strobe_reg;

    logic        is_ram;
    logic        is_mmio;
    logic [3:0]  offset;
    logic        ram_en;

    assign is_ram  = {1'b0, addr_reg} < DEPTH_L;
    assign is_mmio = !is_ram && (addr_reg >= MMIO_BASE);
    // The window is 16 words, so only the low nibble of the difference matters.
    assign offset  = addr_reg[3:0] - MMIO_BASE[3:0];

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        complete   = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (req) begin
                    cnt_next   = WAIT_L;
                    state_next = (WAIT_L == 4'd0) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_next = cnt_reg - 4'd1;
                if (cnt_reg == 4'd1) begin
                    state_next = S_RESP;
                end
            end
            S_RESP: begin
                complete   = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= S_IDLE;
            cnt_reg   <= 4'd0;
            addr_reg  <= 16'd0;
            wr_reg    <= 1'b0;
            wdata_reg <= 16'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (state_reg == S_IDLE && req) begin
                addr_reg  <= base;
                wr_reg    <= flag;
                wdata_reg <= wdata;
            end
        end
    end

    // Synchronous-read RAM; enable gated by reset so an abandoned access never commits.
    assign ram_en = complete && is_ram && !reset;

    always_ff @(posedge clk) begin
        if (ram_en) begin
            if (wr_reg) begin
                mem[addr_reg[AW-1:0]] <= wdata_reg;
            end else begin
                ram_q <= mem[addr_reg[AW-1:0]];
            end
        end
    end

`ifdef MEM_BUS_OOR_ERR_EN
    logic is_oor;
    logic sticky_err_reg;
    logic err_reg;

    assign is_oor      = !is_ram && !is_mmio;
    assign status_word = {15'd0, sticky_err_reg};
    assign err         = err_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            sticky_err_reg <= 1'b0;
            err_reg        <= 1'b0;
        end else begin
            err_reg <= complete && is_oor;
            if (complete && is_oor) begin
                sticky_err_reg <= 1'b1;
            end else if (complete && !wr_reg && is_mmio && offset == 4'd2) begin
                sticky_err_reg <= 1'b0;
            end
        end
    end
`else
    assign status_word = 16'd0;
    assign err         = 1'b0;
`endif

    always_comb begin
        mmio_rd = 16'd0;
        if (is_mmio) begin
            case (offset)
                4'd0:    mmio_rd = in;
                4'd1:    mmio_rd = out_port_reg;
                4'd2:    mmio_rd = status_word;
                default: mmio_rd = 16'd0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ready_reg      <= 1'b0;
            out_strobe_reg <= 1'b0;
            out_port_reg   <= 16'd0;
            mmio_q_reg     <= 16'd0;
            src_ram_reg    <= 1'b0;
        end else begin
            ready_reg      <= complete;
            out_strobe_reg <= complete && wr_reg && is_mmio && offset == 4'd1;
            if (complete && wr_reg && is_mmio && offset == 4'd1) begin
                out_port_reg <= wdata_reg;
            end
            // Non-RAM reads (MMIO and out-of-range) are captured here; RAM reads come from ram_q.
            if (complete && !wr_reg) begin
                src_ram_reg <= is_ram;
                if (!is_ram) begin
                    mmio_q_reg <= mmio_rd;
                end
            end
        end
    end

    assign rdata      = src_ram_reg ? ram_q : mmio_q_reg;
    assign ready      = ready_reg;
    assign out_port   = out_port_reg;
    assign out_strobe = out_strobe_reg;

endmodule

// File: tb/tb_cpu_mem_bus_ctrl.sv
// Directed self-checking bench for cpu_mem_bus_ctrl (DEPTH=1024, WAIT_CYCLES=1, MMIO at 0xFFF0).
module tb_cpu_mem_bus_ctrl;
    logic        clk;
    logic        reset;
    logic        req;
    logic [15:0] base;
    logic        flag;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic        ready;
    logic [15:0] in_port;
    logic [15:0] out_port;
    logic        out_strobe;
    logic        err;

    int checks   = 0;
    int failures = 0;

`ifdef MEM_BUS_OOR_ERR_EN
    localparam logic OOR_EN = 1'b1;
`else
    localparam logic OOR_EN = 1'b0;
`endif

    cpu_mem_bus_ctrl #(.DEPTH(1024), .WAIT_CYCLES(1), .MMIO_BASE(16'hFFF0)) dut (
        .clk(clk), .reset(reset), .req(req), .base(base), .flag(flag), .wdata(wdata),
        .rdata(rdata), .ready(ready), .in(in_port), .out_port(out_port),
        .out_strobe(out_strobe), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issues one access with a one-cycle req, scrambles the inputs afterwards,
    // and reports how many edges after the request edge ready was first seen.
    task automatic access(input logic [15:0] a, input logic w, input logic [15:0] d,
                          output int lat, output logic [15:0] rd,
                          output logic strb, output logic e);
        @(negedge clk);
        req = 1'b1; base = a; flag = w; wdata = d;
        lat = -1; rd = 16'h0; strb = 1'b0; e = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1) begin
                req = 1'b0; base = 16'h0; flag = ~w; wdata = 16'hDEAD;
            end
            if (ready) begin
                lat = k - 1; rd = rdata; strb = out_strobe; e = err;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; req = 1'b0; base = 16'h0; flag = 1'b0; wdata = 16'h0; in_port = 16'h0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        checks++; if (ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", ready); end
        checks++; if (rdata !== 16'h0) begin failures++; $display("FAIL reset_rdata got=%h exp=0000", rdata); end
        checks++; if (out_port !== 16'h0) begin failures++; $display("FAIL reset_out_port got=%h exp=0000", out_port); end
        checks++; if (out_strobe !== 1'b0 || err !== 1'b0) begin failures++; $display("FAIL reset_strobe_err got=%b%b exp=00", out_strobe, err); end
        $display("reset: ready=%b rdata=%h out_port=%h", ready, rdata, out_port);
    endtask

    task automatic test_ram_rw();
        int lat; logic [15:0] rd; logic s, e;
        access(16'h0005, 1'b1, 16'h1234, lat, rd, s, e);
        $display("write 0005=1234 lat=%0d", lat);
        checks++; if (lat !== 2) begin failures++; $display("FAIL ram_wr_latency got=%0d exp=2", lat); end
        @(negedge clk);
        checks++; if (ready !== 1'b0) begin failures++; $display("FAIL ready_single_cycle got=%b exp=0", ready); end
        access(16'h0005, 1'b0, 16'h0, lat, rd, s, e);
        $display("read 0005 -> %h lat=%0d", rd, lat);
        checks++; if (lat !== 2 || rd !== 16'h1234) begin failures++; $display("FAIL ram_rd got=%h/%0d exp=1234/2", rd, lat); end
        access(16'h03FF, 1'b1, 16'h00FF, lat, rd, s, e);
        $display("write 03FF=00FF rdata=%h", rd);
        checks++; if (rd !== 16'h1234) begin failures++; $display("FAIL rdata_hold_on_write got=%h exp=1234", rd); end
        access(16'h03FF, 1'b0, 16'h0, lat, rd, s, e);
        $display("read 03FF -> %h", rd);
        checks++; if (rd !== 16'h00FF) begin failures++; $display("FAIL ram_top_word got=%h exp=00ff", rd); end
    endtask

    task automatic test_out_port();
        int lat; logic [15:0] rd; logic s, e;
        access(16'hFFF1, 1'b1, 16'hBEEF, lat, rd, s, e);
        $display("write FFF1=BEEF strobe=%b out_port=%h", s, out_port);
        checks++; if (s !== 1'b1) begin failures++; $display("FAIL out_strobe_with_ready got=%b exp=1", s); end
        checks++; if (out_port !== 16'hBEEF) begin failures++; $display("FAIL out_port got=%h exp=beef", out_port); end
        @(negedge clk);
        checks++; if (out_strobe !== 1'b0) begin failures++; $display("FAIL out_strobe_single got=%b exp=0", out_strobe); end
        access(16'hFFF1, 1'b0, 16'h0, lat, rd, s, e);
        $display("read FFF1 -> %h", rd);
        checks++; if (rd !== 16'hBEEF) begin failures++; $display("FAIL out_port_readback got=%h exp=beef", rd); end
    endtask

    task automatic test_in_port();
        int lat; logic [15:0] rd; logic s, e;
        in_port = 16'h00A5;
        access(16'hFFF0, 1'b0, 16'h0, lat, rd, s, e);
        $display("read FFF0 -> %h", rd);
        checks++; if (rd !== 16'h00A5) begin failures++; $display("FAIL in_port_read got=%h exp=00a5", rd); end
        in_port = 16'h0000;
        repeat (2) @(negedge clk);
        checks++; if (rdata !== 16'h00A5) begin failures++; $display("FAIL in_port_hold got=%h exp=00a5", rdata); end
    endtask

    task automatic test_reset_mid();
        int lat; logic [15:0] rd; logic s, e; int seen;
        access(16'h0010, 1'b1, 16'h0000, lat, rd, s, e);
        @(negedge clk);
        req = 1'b1; base = 16'h0010; flag = 1'b1; wdata = 16'h5555;
        @(negedge clk);
        req = 1'b0; reset = 1'b1;
        seen = 0;
        repeat (2) begin @(negedge clk); if (ready) seen++; end
        reset = 1'b0;
        repeat (2) begin @(negedge clk); if (ready) seen++; end
        $display("reset in WAIT: ready pulses=%0d", seen);
        checks++; if (seen !== 0) begin failures++; $display("FAIL abandoned_no_ready got=%0d exp=0", seen); end
        checks++; if (rdata !== 16'h0) begin failures++; $display("FAIL rdata_after_reset got=%h exp=0000", rdata); end
        access(16'h0010, 1'b0, 16'h0, lat, rd, s, e);
        $display("read 0010 -> %h", rd);
        checks++; if (rd !== 16'h0000) begin failures++; $display("FAIL abandoned_write got=%h exp=0000", rd); end
    endtask

    task automatic test_back_to_back();
        logic exp_r;
        @(negedge clk);
        req = 1'b1; base = 16'h0001; flag = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            exp_r = (k % 3 == 0);
            $display("held req cycle %0d ready=%b", k, ready);
            checks++; if (ready !== exp_r) begin failures++; $display("FAIL b2b_ready_k%0d got=%b exp=%b", k, ready, exp_r); end
        end
        req = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_oor();
        int lat; logic [15:0] rd; logic s, e;
        access(16'h2000, 1'b0, 16'h0, lat, rd, s, e);
        $display("read 2000 -> %h err=%b", rd, e);
        checks++; if (rd !== 16'h0 || lat !== 2) begin failures++; $display("FAIL oor_read got=%h/%0d exp=0000/2", rd, lat); end
        checks++; if (e !== OOR_EN) begin failures++; $display("FAIL oor_err got=%b exp=%b", e, OOR_EN); end
        access(16'h0000, 1'b1, 16'h1111, lat, rd, s, e);
        access(16'h0400, 1'b1, 16'hAAAA, lat, rd, s, e);
        access(16'h0000, 1'b0, 16'h0, lat, rd, s, e);
        $display("read 0000 after oor write -> %h", rd);
        checks++; if (rd !== 16'h1111) begin failures++; $display("FAIL oor_write_dropped got=%h exp=1111", rd); end
        access(16'hFFF2, 1'b0, 16'h0, lat, rd, s, e);
        $display("read FFF2 -> %h", rd);
        checks++; if (rd !== {15'd0, OOR_EN}) begin failures++; $display("FAIL status_first got=%h exp=%h", rd, {15'd0, OOR_EN}); end
        access(16'hFFF2, 1'b0, 16'h0, lat, rd, s, e);
        $display("read FFF2 again -> %h", rd);
        checks++; if (rd !== 16'h0) begin failures++; $display("FAIL status_cleared got=%h exp=0000", rd); end
        access(16'hFFF5, 1'b0, 16'h0, lat, rd, s, e);
        $display("read FFF5 -> %h", rd);
        checks++; if (rd !== 16'h0) begin failures++; $display("FAIL mmio_reserved got=%h exp=0000", rd); end
    endtask

    initial begin
        test_reset();
        test_ram_rw();
        test_out_port();
        test_in_port();
        test_reset_mid();
        test_back_to_back();
        test_oor();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/cpu_mem_bus_ctrl.md
Name: cpu_mem_bus_ctrl

Overview:
Memory/IO bus controller directly downstream of the 16-bit CPU. It consumes the CPU's address (base), r/w flag and write data, and returns read data with a ready handshake. It decodes addresses to an internal word RAM or a small memory-mapped I/O window: an external input port, an output register, and a status word. Access latency is fixed and set by a wait-state parameter.

Parameters:
DEPTH, 1024, RAM words; power of 2; RAM index = base[$clog2(DEPTH)-1:0]
WAIT_CYCLES, 1, extra wait states per access; legal range 0..15
MMIO_BASE, 16'hFFF0, first MMIO address; window is MMIO_BASE..MMIO_BASE+15

Ports:
clk  in  1  system clock; all logic on rising edge
reset  in  1  synchronous, active-high
req  in  1  CPU access request, sampled only in IDLE
base  in  16  access address
flag  in  1  r/w flag: 1 = write, 0 = read
wdata  in  16  write data
rdata  out  16  read data; valid while ready=1; held until the next read completes
ready  out  1  one-cycle completion pulse
in  in  16  external input port
out_port  out  16  output register
out_strobe  out  1  one-cycle pulse when out_port is written
err  out  1  one-cycle out-of-range pulse; constant 0 without the macro

Behaviour:
- Reset: state IDLE; ready=0, rdata=0, out_port=0, out_strobe=0, err=0, sticky error=0.
- Reset does not clear RAM contents.
- Reset has priority over req in the same cycle.
- FSM states: IDLE, WAIT, RESP. Every access runs through this sequence.
- IDLE + req=1 at edge N: latch base, flag and wdata; load the wait counter with WAIT_CYCLES.
  - Next state is WAIT if WAIT_CYCLES>0, otherwise RESP.
- WAIT: counter decrements each cycle. Goes to RESP on the edge where the counter reaches 0.
- RESP: ready=1 for exactly one cycle, starting at edge N+1+WAIT_CYCLES. Then always returns to IDLE.
- Commit timing: a write commits, and rdata updates, on the same edge at which ready rises.
- req is ignored outside IDLE. If req is still high in the IDLE cycle after RESP, a new access starts.
  - Back-to-back throughput is therefore one access per WAIT_CYCLES+2 cycles.
- All inputs are used only from the latched copies; changes after edge N do not affect the current access.
- Address decode uses the latched address A:
  - A < DEPTH: RAM read/write.
  - A >= MMIO_BASE: MMIO, offset = A - MMIO_BASE:
    - offset 0: read returns in, sampled at the ready-rise edge; write ignored.
    - offset 1: read returns out_port. Write loads out_port and pulses out_strobe, coincident with ready.
    - offset 2: status. Read returns {15'b0, sticky_err}; write ignored.
    - offsets 3..15: read returns 0; write ignored.
  - DEPTH <= A < MMIO_BASE: out of range. Read returns 0; write dropped.
- Reset asserted in WAIT or RESP: the access is abandoned. No write commit, no ready, no strobe.
- Read of the status word with the sticky bit set: returns 1 and clears the bit at the same edge.
- If a new error occurs while the sticky bit is 1, the bit stays 1.

Optional Feature:
Macro MEM_BUS_OOR_ERR_EN.
- Defined:
  - An out-of-range access pulses err together with ready.
  - The same access sets sticky_err.
  - The status word reports sticky_err; reading it clears it.
- Not defined:
  - err is tied to 0 and sticky_err does not exist.
  - The status word reads 0.
  - Out-of-range accesses still read 0 and drop writes.

Test Plan:
- Write/read RAM, WAIT_CYCLES=1: reset 2 cycles; write 0x1234 to 0x0005 with a 1-cycle req. ready is high exactly at edge N+2. Then read 0x0005 -> rdata=0x1234 with ready.
- Output port: write 0xBEEF to 0xFFF1 -> out_port=0xBEEF, out_strobe high for exactly the ready cycle. Read 0xFFF1 -> 0xBEEF.
- Input port: drive in=0x00A5, read 0xFFF0 -> rdata=0x00A5. Change in to 0x0000 after ready -> rdata holds 0x00A5.
- Reset mid-access: write 0x0000 to 0x0010, then start a write of 0x5555 to 0x0010 and assert reset during WAIT. Expect no ready. After reset, read 0x0010 -> 0x0000.
- Held req: req=1 continuously, reading 0x0001, WAIT_CYCLES=1 -> ready pulses every 3 cycles, each a single cycle.
- Out-of-range, DEPTH=1024:
  - With MEM_BUS_OOR_ERR_EN: read 0x2000 -> rdata=0 and an err pulse. Read 0xFFF2 -> 0x0001; read 0xFFF2 again -> 0x0000.
  - Without the macro: err stays 0 and 0xFFF2 reads 0x0000.
